// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types, word width, sequencer states and decoder flag bundle
package cpu_pkg;
    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
    localparam word_t RESET_PC_DEF = 16'h0000;
    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;
    typedef struct packed {
        logic is_halt;
        logic is_branch;
        logic is_load;
        logic is_store;
    } dec_flags_t;
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: single-port memory request/acknowledge bus
interface cpu_sequencer_if;
    import cpu_pkg::*;
    logic  mem_req;
    logic  mem_we;
    word_t mem_addr;
    logic  mem_ack;
    word_t mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem/wb sequencer owning PC, IR and retire count
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_sequencer_if.master        mem,
    output word_t                  instr,
    input  logic                   dec_is_halt,
    input  logic                   dec_is_branch,
    input  logic                   dec_is_load,
    input  logic                   dec_is_store,
    input  word_t                  dec_target,
    input  logic                   br_taken,
    input  word_t                  ls_addr,
    output word_t                  pc,
    output logic                   rf_we,
    output logic                   halted,
    output word_t                  retired,
    output logic [2:0]             icycle
);
    state_t     state_q, state_d;
    word_t      pc_q, pc_d, instr_q, instr_d, ls_addr_q, ls_addr_d, retired_q, retired_d;
    logic       st_q, st_d, ret;
    dec_flags_t dec;
    assign dec = '{is_halt: dec_is_halt, is_branch: dec_is_branch,
                   is_load: dec_is_load, is_store: dec_is_store};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            ls_addr_q <= '0;
            st_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ls_addr_q <= ls_addr_d;
            st_q      <= st_d;
            retired_q <= retired_d;
        end
    end
    always_comb begin
        state_d   = S_BOOT;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ls_addr_d = ls_addr_q;
        st_d      = st_q;
        ret       = 1'b0;
        case (state_q)
            S_BOOT:   state_d = S_FETCH;
            S_FETCH: begin
                state_d = mem.mem_ack ? S_DECODE : S_FETCH;
                if (mem.mem_ack) begin
                    instr_d = mem.mem_rdata;
                    pc_d    = pc_q + 16'd1;
                end
            end
            S_DECODE: state_d = dec.is_halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (dec.is_halt) begin
                    state_d = S_HALT;
                end else if (dec.is_branch) begin
                    pc_d    = br_taken ? dec_target : pc_q;
                    ret     = 1'b1;
                    state_d = S_FETCH;
                end else if (dec.is_load || dec.is_store) begin
                    // load wins over store when both flags are set
                    ls_addr_d = ls_addr;
                    st_d      = !dec.is_load;
                    state_d   = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                state_d = !mem.mem_ack ? S_MEM : st_q ? S_FETCH : S_WB;
                ret     = mem.mem_ack && st_q;
            end
            S_WB: begin
                ret     = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_BOOT;
        endcase
        retired_d = retired_q + word_t'(ret);
    end
    assign mem.mem_req  = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem.mem_we   = (state_q == S_MEM) && st_q;
    assign mem.mem_addr = (state_q == S_FETCH) ? pc_q : (state_q == S_MEM) ? ls_addr_q : '0;
    assign instr   = instr_q;
    assign pc      = pc_q;
    assign rf_we   = state_q == S_WB;
    assign halted  = state_q == S_HALT;
    assign retired = retired_q;
    assign icycle  = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboarded bench with a latency-programmable memory and a nibble-coded decoder
module tb_cpu_sequencer;
    import cpu_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    cpu_sequencer_if bus();
    word_t instr, pc, retired;
    word_t dec_target = '0;
    word_t ls_addr = '0;
    logic  br_taken = 1'b0;
    logic  dec_is_halt, dec_is_branch, dec_is_load, dec_is_store, rf_we, halted;
    logic [2:0] icycle;
    typedef struct packed {
        logic  we;
        word_t addr;
    } txn_t;
    txn_t  sb[$];
    int    errs = 0;
    int    checks = 0;
    int    lat_cfg = 0;
    int    wcnt = 0;
    word_t cur_word = '0;
    word_t mpc = '0;
    word_t mret = '0;

    cpu_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem(bus.master), .instr(instr),
        .dec_is_halt(dec_is_halt), .dec_is_branch(dec_is_branch),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_target(dec_target), .br_taken(br_taken), .ls_addr(ls_addr),
        .pc(pc), .rf_we(rf_we), .halted(halted), .retired(retired), .icycle(icycle)
    );

    // opcode nibble: 0 ALU, 1 branch, 2 load, 3 store, F halt
    assign dec_is_halt   = instr[15:12] == 4'hF;
    assign dec_is_branch = instr[15:12] == 4'h1;
    assign dec_is_load   = instr[15:12] == 4'h2;
    assign dec_is_store  = instr[15:12] == 4'h3;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory: acks after lat_cfg wait cycles, spurious ack whenever no request is pending
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end else if (bus.mem_req) begin
            bus.mem_rdata = cur_word;
            chk("sb_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("bus", 32'({bus.mem_we, bus.mem_addr}), 32'(sb[0]));
            if (wcnt >= lat_cfg) begin
                bus.mem_ack = 1'b1;
                wcnt = 0;
                if (sb.size() != 0) void'(sb.pop_front());
            end else begin
                bus.mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = 16'hdead;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, icycle, 0);
        chk({tag, "_req"}, bus.mem_req, 0);
        chk({tag, "_we"}, bus.mem_we, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_pc"}, pc, 16'h0000);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_rfwe"}, rf_we, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_retired"}, retired, 0);
    endtask

    // called at a FETCH negedge; runs one instruction until the next FETCH
    task automatic run(input word_t w, input int lat, input word_t lsa, input logic tk, input word_t tgt);
        int n, rf, exp_n, exp_rf;
        logic left;
        n = 0; rf = 0; left = 1'b0;
        cur_word = w; lat_cfg = lat; ls_addr = lsa; br_taken = tk; dec_target = tgt;
        sb.push_back({1'b0, mpc});
        mpc = mpc + 16'd1;
        mret = mret + 16'd1;
        case (w[15:12])
            4'h1: begin exp_n = 3 + lat; exp_rf = 0; if (tk) mpc = tgt; end
            4'h2: begin exp_n = 5 + 2 * lat; exp_rf = 1; sb.push_back({1'b0, lsa}); end
            4'h3: begin exp_n = 4 + 2 * lat; exp_rf = 0; sb.push_back({1'b1, lsa}); end
            default: begin exp_n = 4 + lat; exp_rf = 1; end
        endcase
        for (int k = 0; k < 64; k++) begin
            if (icycle == 3'd4) ls_addr = ~lsa;
            @(negedge clk);
            n++;
            if (rf_we) rf++;
            if (icycle != 3'd1) left = 1'b1;
            if (icycle == 3'd1 && left) break;
        end
        chk("cycles", n, exp_n);
        chk("rf_we_pulses", rf, exp_rf);
        chk("pc", pc, mpc);
        chk("instr", instr, w);
        chk("retired", retired, mret);
    endtask

    task automatic run_halt();
        int n, bad;
        n = 0; bad = 0;
        cur_word = 16'hF000; lat_cfg = 0;
        sb.push_back({1'b0, mpc});
        mpc = mpc + 16'd1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (icycle == 3'd6) break;
        end
        chk("halt_cycles", n, 2);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b0 || halted !== 1'b1 || icycle !== 3'd6 || rf_we !== 1'b0) bad++;
        end
        chk("halt_hold", bad, 0);
        chk("halt_retired", retired, mret);
        chk("halt_pc", pc, mpc);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("por");
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("boot_to_fetch", icycle, 1);
        chk("first_fetch_addr", bus.mem_addr, 16'h0000);
        run(16'h025a, 0, '0, 1'b0, '0);
        run(16'h0111, 1, '0, 1'b0, '0);
        run(16'h0222, 0, '0, 1'b0, '0);
        run(16'h0333, 2, '0, 1'b0, '0);
        run(16'h1000, 0, '0, 1'b0, 16'h0080);
        run(16'h1000, 0, '0, 1'b1, 16'h0040);
        run(16'h2000, 2, 16'h1234, 1'b0, '0);
        run(16'h3000, 0, 16'h0abc, 1'b0, '0);
        run(16'h3000, 3, 16'h5555, 1'b0, '0);
        run(16'h1000, 1, '0, 1'b1, 16'hFFFF);
        run(16'h0444, 0, '0, 1'b0, '0);
        chk("pc_wrap", pc, 16'h0000);
        run_halt();
        #2 reset = 1'b0;
        #1 chk_reset("halt_rst");
        sb.delete();
        mpc = '0; mret = '0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        run(16'h0555, 0, '0, 1'b0, '0);
        lat_cfg = 10; cur_word = 16'h0666;
        sb.push_back({1'b0, mpc});
        repeat (3) @(negedge clk);
        chk("mid_wait_req", bus.mem_req, 1);
        #3 reset = 1'b0;
        #1 chk_reset("mid_rst");
        sb.delete();
        mpc = '0; mret = '0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        run(16'h0777, 0, '0, 1'b0, '0);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 16-bit CPU. It owns the program counter and instruction register, and drives fetch/decode/execute/memory/writeback through a Moore state machine. It arbitrates the single memory port between instruction fetch and load/store, and presents the latched instruction word to `decoder`. It sits between the memory interface and the decoder/datapath.

## Interface
- `RESET_PC`, default `16'h0000`: PC value after reset.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserted (0) forces the reset values immediately.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: 1 = store, 0 = read. Valid while `mem_req`.
- `mem_addr` out 16: memory word address. Valid while `mem_req`.
- `mem_ack` in 1: memory completion. Sampled only while `mem_req` = 1.
- `mem_rdata` in 16: read data, valid in the `mem_ack` cycle.
- `instr` out 16: instruction register, fed to `decoder`.
- `dec_is_halt`, `dec_is_branch`, `dec_is_load`, `dec_is_store` in 1 each: decoder class flags, valid in DECODE and EXEC.
- `dec_target` in 16: branch target, valid in EXEC.
- `br_taken` in 1: branch condition from the datapath, valid in EXEC.
- `ls_addr` in 16: load/store address from the datapath, valid in EXEC.
- `pc` out 16: current program counter.
- `rf_we` out 1: register-file write strobe, one cycle.
- `halted` out 1: high in HALT.
- `retired` out 16: retired-instruction count.
- `icycle` out 3: current state encoding, for debug.

## Operation
- States: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encodings 7 and above go to BOOT on the next clock.
- Reset values: state BOOT, `pc`=`RESET_PC`, `instr`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `rf_we`=0, `halted`=0, `retired`=0.
- BOOT: all strobes low; go to FETCH next cycle.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - On `mem_ack`: `instr`<=`mem_rdata`, `pc`<=`pc`+1 (16-bit wrap, `16'hFFFF`->0), go to DECODE.
- DECODE: one cycle for decoder settle.
  - If `dec_is_halt`, go to HALT.
  - Otherwise go to EXEC.
- EXEC: class priority is halt > branch > load > store > ALU.
  - Branch: if `br_taken`, `pc`<=`dec_target`. Retire, go to FETCH.
  - Load or store: latch `ls_addr` and the store flag into internal registers, go to MEM.
  - ALU: go to WB.
- MEM: `mem_req`=1, `mem_addr`=latched address, `mem_we`=latched store flag.
  - On `mem_ack`, load: go to WB.
  - On `mem_ack`, store: retire, go to FETCH.
- WB: `rf_we`=1 for one cycle, retire, go to FETCH.
- HALT: `halted`=1, all strobes 0. Only reset exits HALT. HALT is not counted as retired.
- Retire: `retired`<=`retired`+1, wrapping from `16'hFFFF` to 0.
- Memory handshake:
  - `mem_req`, `mem_addr` and `mem_we` stay stable from assertion until the `mem_ack` cycle.
  - `mem_ack` while `mem_req`=0 is ignored.
  - Zero-wait memory (ack in the first request cycle) is supported.
- Reset mid-access: the request is abandoned and `mem_req` drops asynchronously. The memory must tolerate this.

## Timing
- All outputs are functions of registered state only; no input-to-output combinational path.
- Cycles per instruction with zero-wait memory:
  - Branch: 3 (FETCH, DECODE, EXEC).
  - Store: 4.
  - ALU: 4.
  - Load: 5.
  - Each memory wait cycle adds 1.
- `instr` and `pc` update on the clock edge of the fetch `mem_ack`.
- `rf_we` is high exactly in the WB cycle.
- A taken branch updates `pc` on the EXEC edge; the next FETCH uses the target.

## Structure
- Shared package `cpu_pkg` holds:
  - The state enum.
  - Word width 16.
  - The default `RESET_PC`.
  - The decoder-flag struct used by both `decoder` and `cpu_sequencer`.
- Single module, no sub-modules. Contents: FSM, PC, IR, the latched load/store address and store flag, and the retire counter.

## Test plan
- Reset release, zero-wait memory returning `16'h025a` (ALU class): BOOT, FETCH with `mem_addr`=0, DECODE, EXEC, WB with `rf_we`=1. Then `pc`=1, `instr`=`16'h025a`, `retired`=1, next FETCH `mem_addr`=1.
- Taken branch at `pc`=4 with `dec_target`=`16'h0040`: next FETCH `mem_addr`=`16'h0040`. Not taken: next FETCH `mem_addr`=5. Each takes 3 cycles.
- Load with `ls_addr`=`16'h1234` and 3-cycle memory latency: MEM holds `mem_req`=1, `mem_addr`=`16'h1234`, `mem_we`=0 for 3 cycles even if `ls_addr` changes, then WB.
- Store: `mem_we`=1 throughout MEM, no `rf_we`, `retired` increments on ack.
- Halt flag in DECODE: HALT next cycle, `halted`=1, `mem_req` stays 0 for 20 cycles, `retired` unchanged. Reset returns `pc`=`RESET_PC`.
- Reset asserted mid-FETCH wait: `mem_req` drops immediately, all outputs take their reset values. `pc`=`16'hFFFF` fetch wraps `pc` to 0.
